bfly_addsub_pipe: RTL and testbench

Parametrised, pipelined radix-2 butterfly add/subtract stage for the FFT datapath. It takes `LANES` complex pairs per beat and produces sum and difference per lane, `dout1 = din2 + din1` and `dout2 = din2 - din1`. It has an optional per-beat divide-by-2 with rounding for block-floating-point scaling. It sits between the twiddle multiplier and the stage buffer, uses a valid/ready handshake with full-throughput backpressure, and reports a sticky growth flag and a beat counter to the FFT controller.

---
 rtl/bfly_addsub_pipe.sv | 148 ++++++++++++++
 tb/tb_bfly_addsub_pipe.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfly_addsub_pipe.sv
// Two-stage radix-2 butterfly: S1 registers operands, S2 registers sum/difference
// with optional round-half-up halving, plus a sticky growth flag and a delivered-beat counter.
module bfly_addsub_pipe #(
    parameter int WIDTH = 10,
    parameter int LANES = 16,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         scale_en,
    input  logic [LANES*WIDTH-1:0]       din1_re,
    input  logic [LANES*WIDTH-1:0]       din1_im,
    input  logic [LANES*WIDTH-1:0]       din2_re,
    input  logic [LANES*WIDTH-1:0]       din2_im,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*(WIDTH+1)-1:0]   dout1_re,
    output logic [LANES*(WIDTH+1)-1:0]   dout1_im,
    output logic [LANES*(WIDTH+1)-1:0]   dout2_re,
    output logic [LANES*(WIDTH+1)-1:0]   dout2_im,
    output logic                         grow_flag,
    input  logic                         grow_clr,
    output logic [CNT_W-1:0]             beat_cnt
);

    localparam int IW = LANES * WIDTH;
    localparam int OW = LANES * (WIDTH + 1);

    logic              s1_valid_reg;
    logic              s1_scale_reg;
    logic [IW-1:0]     s1_d1re_reg, s1_d1im_reg, s1_d2re_reg, s1_d2im_reg;
    logic              out_valid_reg;
    logic [OW-1:0]     d1re_reg, d1im_reg, d2re_reg, d2im_reg;
    logic [OW-1:0]     d1re_next, d1im_next, d2re_next, d2im_next;
    logic [4*LANES-1:0] lane_grow;
    logic              grow_flag_reg, grow_flag_next;
    logic [CNT_W-1:0]  beat_cnt_reg, beat_cnt_next;

    logic s2_ready, s1_ready, s1_load, s2_load, detect, deliver;

    assign s2_ready = !out_valid_reg || out_ready;
    assign s1_ready = !s1_valid_reg || s2_ready;
    assign s1_load  = in_valid && s1_ready;
    assign s2_load  = s1_valid_reg && s2_ready;
    assign deliver  = out_valid_reg && out_ready;

    // (x + 1) >>> 1 evaluated one bit wider so the rounding increment cannot wrap
    function automatic logic [WIDTH:0] scale_res(input logic [WIDTH:0] x, input logic sc);
        logic [WIDTH+1:0] t;
        t = {x[WIDTH], x} + {{(WIDTH+1){1'b0}}, 1'b1};
        return sc ? t[WIDTH+1:1] : x;
    endfunction

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [WIDTH:0] a1_re, a1_im, a2_re, a2_im;
            logic [WIDTH:0] r1_re, r1_im, r2_re, r2_im;

            assign a1_re = {s1_d1re_reg[gi*WIDTH+WIDTH-1], s1_d1re_reg[gi*WIDTH +: WIDTH]};
            assign a1_im = {s1_d1im_reg[gi*WIDTH+WIDTH-1], s1_d1im_reg[gi*WIDTH +: WIDTH]};
            assign a2_re = {s1_d2re_reg[gi*WIDTH+WIDTH-1], s1_d2re_reg[gi*WIDTH +: WIDTH]};
            assign a2_im = {s1_d2im_reg[gi*WIDTH+WIDTH-1], s1_d2im_reg[gi*WIDTH +: WIDTH]};

            assign r1_re = scale_res(a2_re + a1_re, s1_scale_reg);
            assign r1_im = scale_res(a2_im + a1_im, s1_scale_reg);
            assign r2_re = scale_res(a2_re - a1_re, s1_scale_reg);
            assign r2_im = scale_res(a2_im - a1_im, s1_scale_reg);

            assign d1re_next[gi*(WIDTH+1) +: WIDTH+1] = r1_re;
            assign d1im_next[gi*(WIDTH+1) +: WIDTH+1] = r1_im;
            assign d2re_next[gi*(WIDTH+1) +: WIDTH+1] = r2_re;
            assign d2im_next[gi*(WIDTH+1) +: WIDTH+1] = r2_im;

            // Result leaves the WIDTH-bit range when the top two bits disagree
            assign lane_grow[4*gi+0] = r1_re[WIDTH] ^ r1_re[WIDTH-1];
            assign lane_grow[4*gi+1] = r1_im[WIDTH] ^ r1_im[WIDTH-1];
            assign lane_grow[4*gi+2] = r2_re[WIDTH] ^ r2_re[WIDTH-1];
            assign lane_grow[4*gi+3] = r2_im[WIDTH] ^ r2_im[WIDTH-1];
        end
    endgenerate

    assign detect = |lane_grow;

    // Clear only drops history; a growing beat loading on the same edge still sets the flag
    always_comb begin
        grow_flag_next = grow_flag_reg;
        if (s2_load)
            grow_flag_next = (grow_flag_reg & ~grow_clr) | detect;
        else if (grow_clr)
            grow_flag_next = 1'b0;
    end

    always_comb begin
        beat_cnt_next = beat_cnt_reg;
        if (deliver)
            beat_cnt_next = beat_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_reg  <= 1'b0;
            s1_scale_reg  <= 1'b0;
            s1_d1re_reg   <= '0;
            s1_d1im_reg   <= '0;
            s1_d2re_reg   <= '0;
            s1_d2im_reg   <= '0;
            out_valid_reg <= 1'b0;
            d1re_reg      <= '0;
            d1im_reg      <= '0;
            d2re_reg      <= '0;
            d2im_reg      <= '0;
            grow_flag_reg <= 1'b0;
            beat_cnt_reg  <= '0;
        end else begin
            if (s1_ready)
                s1_valid_reg <= in_valid;
            if (s1_load) begin
                s1_scale_reg <= scale_en;
                s1_d1re_reg  <= din1_re;
                s1_d1im_reg  <= din1_im;
                s1_d2re_reg  <= din2_re;
                s1_d2im_reg  <= din2_im;
            end
            if (s2_ready)
                out_valid_reg <= s1_valid_reg;
            if (s2_load) begin
                d1re_reg <= d1re_next;
                d1im_reg <= d1im_next;
                d2re_reg <= d2re_next;
                d2im_reg <= d2im_next;
            end
            grow_flag_reg <= grow_flag_next;
            beat_cnt_reg  <= beat_cnt_next;
        end
    end

    assign in_ready  = s1_ready;
    assign out_valid = out_valid_reg;
    assign dout1_re  = d1re_reg;
    assign dout1_im  = d1im_reg;
    assign dout2_re  = d2re_reg;
    assign dout2_im  = d2im_reg;
    assign grow_flag = grow_flag_reg;
    assign beat_cnt  = beat_cnt_reg;

endmodule

// File: tb/tb_bfly_addsub_pipe.sv
// Directed + randomized bench for bfly_addsub_pipe; an arithmetic reference model
// feeds a scoreboard queue checked at every delivered beat.
module tb_bfly_addsub_pipe;

    localparam int W  = 10;
    localparam int L  = 16;
    localparam int CW = 4;
    localparam int IW = L * W;
    localparam int OW = L * (W + 1);

    logic          clk = 1'b0;
    logic          rstn;
    logic          in_valid, in_ready, scale_en, out_valid, out_ready;
    logic          grow_flag, grow_clr;
    logic [IW-1:0] din1_re, din1_im, din2_re, din2_im;
    logic [OW-1:0] dout1_re, dout1_im, dout2_re, dout2_im;
    logic [CW-1:0] beat_cnt;

    always #5 clk = ~clk;

    bfly_addsub_pipe #(.WIDTH(W), .LANES(L), .CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .scale_en(scale_en),
        .din1_re(din1_re), .din1_im(din1_im), .din2_re(din2_re), .din2_im(din2_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout1_re(dout1_re), .dout1_im(dout1_im), .dout2_re(dout2_re), .dout2_im(dout2_im),
        .grow_flag(grow_flag), .grow_clr(grow_clr), .beat_cnt(beat_cnt)
    );

    typedef struct packed {
        logic [OW-1:0] d1re, d1im, d2re, d2im;
        logic          grow;
    } beat_t;

    beat_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    exp_cnt = 0;
    bit    grow_acc = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] lv(input int x);
        return x[W:0];
    endfunction

    function automatic int lane_of(input logic [IW-1:0] v, input int i);
        logic [W-1:0] t;
        t = v[i*W +: W];
        return int'($signed(t));
    endfunction

    // Reference: exact integer sum/difference, halved with floor((x+1)/2) when scaling
    function automatic int ref_val(input int a2, input int a1, input bit sub, input bit sc);
        int x, y, q;
        x = sub ? a2 - a1 : a2 + a1;
        if (!sc) return x;
        y = x + 1;
        q = y / 2;
        if (y < 0 && (y % 2) != 0) q = q - 1;
        return q;
    endfunction

    function automatic beat_t model_beat();
        beat_t b;
        int r[4];
        b = '0;
        for (int i = 0; i < L; i++) begin
            r[0] = ref_val(lane_of(din2_re, i), lane_of(din1_re, i), 1'b0, scale_en);
            r[1] = ref_val(lane_of(din2_im, i), lane_of(din1_im, i), 1'b0, scale_en);
            r[2] = ref_val(lane_of(din2_re, i), lane_of(din1_re, i), 1'b1, scale_en);
            r[3] = ref_val(lane_of(din2_im, i), lane_of(din1_im, i), 1'b1, scale_en);
            b.d1re[i*(W+1) +: W+1] = lv(r[0]);
            b.d1im[i*(W+1) +: W+1] = lv(r[1]);
            b.d2re[i*(W+1) +: W+1] = lv(r[2]);
            b.d2im[i*(W+1) +: W+1] = lv(r[3]);
            for (int k = 0; k < 4; k++)
                if (r[k] > 2**(W-1) - 1 || r[k] < -(2**(W-1))) b.grow = 1'b1;
        end
        return b;
    endfunction

    task automatic set_lane(input int i, input int a2re, input int a1re, input int a2im, input int a1im);
        din2_re[i*W +: W] = a2re[W-1:0];
        din1_re[i*W +: W] = a1re[W-1:0];
        din2_im[i*W +: W] = a2im[W-1:0];
        din1_im[i*W +: W] = a1im[W-1:0];
    endtask

    function automatic int rs();
        return int'($urandom_range(0, 400)) - 200;
    endfunction

    task automatic fill(input bit full);
        for (int i = 0; i < L; i++) begin
            if (full) set_lane(i, int'($urandom), int'($urandom), int'($urandom), int'($urandom));
            else      set_lane(i, rs(), rs(), rs(), rs());
        end
    endtask

    // Present one beat and hold it until accepted; returns #1 after the accepting edge
    task automatic send(input bit rnd, output int waits);
        bit acc;
        waits = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            waits++;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            if (acc) break;
        end
        if (!acc) check("send_timeout", in_ready, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        int i;
        for (i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        if (i == 300) check("drain_timeout", exp_q.size(), 0);
        out_ready = 1'b1;
    endtask

    task automatic pulse_clr();
        grow_clr = 1'b1;
        @(posedge clk);
        #1;
        grow_clr = 1'b0;
    endtask

    // Scoreboard: mid-cycle sampling of both handshakes and of stall stability
    task automatic monitor();
        beat_t e, held;
        bit stalled;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                exp_q.delete();
                exp_cnt  = 0;
                grow_acc = 1'b0;
                stalled  = 1'b0;
                continue;
            end
            if (grow_clr) grow_acc = 1'b0;
            if (stalled) begin
                check("hold_valid", out_valid, 1);
                check("hold_d1re", dout1_re, held.d1re);
                check("hold_d1im", dout1_im, held.d1im);
                check("hold_d2re", dout2_re, held.d2re);
                check("hold_d2im", dout2_im, held.d2im);
            end
            if (out_valid && out_ready) begin
                exp_cnt++;
                if (exp_q.size() == 0) begin
                    check("stale_beat", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("dout1_re", dout1_re, e.d1re);
                    check("dout1_im", dout1_im, e.d1im);
                    check("dout2_re", dout2_re, e.d2re);
                    check("dout2_im", dout2_im, e.d2im);
                    grow_acc = grow_acc | e.grow;
                end
            end
            stalled = out_valid && !out_ready;
            if (stalled) begin
                held.d1re = dout1_re;
                held.d1im = dout1_im;
                held.d2re = dout2_re;
                held.d2im = dout2_im;
            end
            if (in_valid && in_ready) exp_q.push_back(model_beat());
        end
    endtask

    initial begin
        int w;
        rstn = 1'b0; in_valid = 1'b0; scale_en = 1'b0; out_ready = 1'b1; grow_clr = 1'b0;
        din1_re = '0; din1_im = '0; din2_re = '0; din2_im = '0;
        fork
            monitor();
        join_none

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_dout1_re", dout1_re, 0);
        check("rst_dout2_im", dout2_im, 0);
        check("rst_grow", grow_flag, 0);
        check("rst_cnt", beat_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // basic arithmetic, scale off
        fill(0);
        set_lane(0, 300, 300, -5, 7);
        scale_en = 1'b0;
        send(0, w);
        check("lat_s1_only", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_out_valid", out_valid, 1);
        check("basic_d1re", dout1_re[W:0], lv(600));
        check("basic_d2re", dout2_re[W:0], lv(0));
        check("basic_d1im", dout1_im[W:0], lv(2));
        check("basic_d2im", dout2_im[W:0], lv(-12));
        check("basic_grow", grow_flag, 1);
        drain(0);
        pulse_clr();
        check("clr_idle", grow_flag, 0);

        // rounding, scale on
        fill(0);
        set_lane(0, 3, 2, 0, 0);
        set_lane(1, -3, 2, 0, 0);
        set_lane(2, 511, -512, 0, 0);
        scale_en = 1'b1;
        send(0, w);
        @(posedge clk);
        #1;
        check("rnd_l0_d1", dout1_re[0 +: W+1], lv(3));
        check("rnd_l0_d2", dout2_re[0 +: W+1], lv(1));
        check("rnd_l1_d1", dout1_re[(W+1) +: W+1], lv(0));
        check("rnd_l1_d2", dout2_re[(W+1) +: W+1], lv(-2));
        check("rnd_l2_d2", dout2_re[2*(W+1) +: W+1], lv(512));
        check("rnd_grow", grow_flag, 1);
        drain(0);

        // two beats in flight under backpressure, then reset mid-stream
        out_ready = 1'b0;
        scale_en = 1'b0;
        fill(0);
        send(0, w);
        fill(0);
        send(0, w);
        check("absorb2_in_ready", in_ready, 0);
        check("absorb2_out_valid", out_valid, 1);
        out_ready = 1'b1;
        #1;
        check("ready_comb", in_ready, 1);
        out_ready = 1'b0;
        #1;
        rstn = 1'b0;
        #2;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_dout1_re", dout1_re, 0);
        check("mid_rst_dout1_im", dout1_im, 0);
        check("mid_rst_dout2_re", dout2_re, 0);
        check("mid_rst_dout2_im", dout2_im, 0);
        check("mid_rst_grow", grow_flag, 0);
        check("mid_rst_cnt", beat_cnt, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("no_stale", out_valid, 0);
        end

        // backpressure stream: 8 incrementing beats, random out_ready
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < L; i++) set_lane(i, 40*k + i, 3*k - i, -20*k + i, k*i);
            scale_en = 1'($urandom_range(0, 1));
            send(1, w);
        end
        drain(1);
        check("bp_cnt", beat_cnt, 8);
        check("bp_grow", grow_flag, 0);

        // random full-range stream
        pulse_clr();
        for (int k = 0; k < 40; k++) begin
            fill(1);
            scale_en = 1'($urandom_range(0, 1));
            send(1, w);
        end
        drain(1);
        check("rand_grow", grow_flag, grow_acc);
        check("rand_cnt", beat_cnt, exp_cnt % (2**CW));

        // growth flag priority
        out_ready = 1'b1;
        scale_en = 1'b0;
        fill(0);
        set_lane(0, 300, 300, 0, 0);
        send(0, w);
        pulse_clr();
        check("prio_detect_wins", grow_flag, 1);
        drain(0);
        fill(0);
        send(0, w);
        pulse_clr();
        check("prio_clear", grow_flag, 0);
        drain(0);

        // counter wrap at 2^CW with back-to-back beats
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 17; k++) begin
            fill(1);
            scale_en = 1'($urandom_range(0, 1));
            send(0, w);
            check("thru_wait", w, 1);
        end
        drain(0);
        check("wrap_cnt", beat_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
